// File: rtl/loader_pkg.sv
// Shared widths, state encoding and helpers for the memory image loader.
package loader_pkg;

    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_W / 8;
    localparam int unsigned BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned MAX_WORDS      = 1 << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_VERIFY, S_DONE} state_e;

    // Requests larger than the memory depth are trimmed to one full pass.
    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] n);
        logic [ADDR_W:0] max_n;
        max_n = (ADDR_W + 1)'(MAX_WORDS);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/mem_image_loader_if.sv
// Host-side control, byte stream and memory write/read-back port of the loader.
interface mem_image_loader_if;

    logic                          start;
    logic [loader_pkg::ADDR_W-1:0] base_addr;
    logic [loader_pkg::ADDR_W:0]   word_count;
    logic [7:0]                    in_byte;
    logic                          in_valid;
    logic                          in_ready;
    logic [loader_pkg::ADDR_W-1:0] mem_a;
    logic [loader_pkg::DATA_W-1:0] mem_d;
    logic                          mem_we;
    logic [loader_pkg::ADDR_W-1:0] mem_dpra;
    logic [loader_pkg::DATA_W-1:0] mem_dpo;
    logic                          busy;
    logic                          done;
    logic                          verify_err;
    logic [loader_pkg::DATA_W-1:0] checksum;

    modport master (
        input  start, base_addr, word_count, in_byte, in_valid, mem_dpo,
        output in_ready, mem_a, mem_d, mem_we, mem_dpra, busy, done, verify_err, checksum
    );

    modport slave (
        output start, base_addr, word_count, in_byte, in_valid, mem_dpo,
        input  in_ready, mem_a, mem_d, mem_we, mem_dpra, busy, done, verify_err, checksum
    );

endinterface

// File: rtl/byte_packer.sv
// Packs accepted stream bytes MSB-first into a memory word.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        in_byte,
    output logic [DATA_W-1:0] word,
    output logic              word_valid,
    output logic              last
);

    logic [BCNT_W-1:0] cnt_q;
    logic [DATA_W-1:0] word_q;
    logic              valid_q;

    // Combinational so the FSM can leave LOAD on the same edge that takes the final byte.
    assign last       = push && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    assign word       = word_q;
    assign word_valid = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= last;
            if (clear) begin
                cnt_q  <= '0;
                word_q <= '0;
            end else if (push) begin
                cnt_q  <= cnt_q + BCNT_W'(1);
                word_q <= {word_q[DATA_W-9:0], in_byte};
            end
        end
    end

endmodule

// File: rtl/mem_image_loader.sv
// Streams a byte image into a distributed memory, then reads it back and checks the sum.
module mem_image_loader
    import loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mem_image_loader_if.master  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   words_left_q, words_left_d;
    logic [ADDR_W:0]   rd_left_q, rd_left_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic [DATA_W-1:0] rd_sum_q, rd_sum_d;
    logic              verify_err_q, verify_err_d;

    logic              pk_clear, pk_push, pk_last, pk_valid;
    logic [DATA_W-1:0] pk_word;

    assign bus.in_ready   = (state_q == S_LOAD);
    assign pk_push        = bus.in_valid && bus.in_ready;
    assign bus.mem_we     = (state_q == S_WRITE) && pk_valid;
    assign bus.mem_a      = (state_q == S_WRITE) ? wr_ptr_q : '0;
    assign bus.mem_d      = (state_q == S_WRITE) ? pk_word : '0;
    assign bus.mem_dpra   = (state_q == S_VERIFY) ? rd_ptr_q : '0;
    assign bus.busy       = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_VERIFY);
    assign bus.done       = (state_q == S_DONE);
    assign bus.verify_err = verify_err_q;
    assign bus.checksum   = checksum_q;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .push       (pk_push),
        .in_byte    (bus.in_byte),
        .word       (pk_word),
        .word_valid (pk_valid),
        .last       (pk_last)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        words_left_d = words_left_q;
        rd_left_d    = rd_left_q;
        checksum_d   = checksum_q;
        rd_sum_d     = rd_sum_q;
        verify_err_d = verify_err_q;
        pk_clear     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d       = bus.base_addr;
                    wr_ptr_d     = bus.base_addr;
                    rd_ptr_d     = bus.base_addr;
                    count_d      = clamp_count(bus.word_count);
                    words_left_d = count_d;
                    rd_left_d    = '0;
                    checksum_d   = '0;
                    rd_sum_d     = '0;
                    verify_err_d = 1'b0;
                    pk_clear     = 1'b1;
                    // An empty load only passes through the (trivially equal) compare step.
                    state_d      = (count_d == '0) ? S_VERIFY : S_LOAD;
                end
            end
            S_LOAD: begin
                if (pk_last) state_d = S_WRITE;
            end
            S_WRITE: begin
                checksum_d   = checksum_q + pk_word;
                wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
                words_left_d = words_left_q - (ADDR_W + 1)'(1);
                if (words_left_q == (ADDR_W + 1)'(1)) begin
                    state_d   = S_VERIFY;
                    rd_ptr_d  = base_q;
                    rd_left_d = count_q;
                    rd_sum_d  = '0;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_VERIFY: begin
                if (rd_left_q != '0) begin
                    rd_sum_d  = rd_sum_q + bus.mem_dpo;
                    rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - (ADDR_W + 1)'(1);
                end else begin
                    verify_err_d = (rd_sum_q != checksum_q);
                    state_d      = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            words_left_q <= '0;
            rd_left_q    <= '0;
            checksum_q   <= '0;
            rd_sum_q     <= '0;
            verify_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            words_left_q <= words_left_d;
            rd_left_q    <= rd_left_d;
            checksum_q   <= checksum_d;
            rd_sum_q     <= rd_sum_d;
            verify_err_q <= verify_err_d;
        end
    end

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed/randomized bench: loads byte images into a behavioural 256x32 memory and checks
// memory contents, write addresses, checksum, verify flag and handshake timing.
module tb_mem_image_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_image_loader_if bus ();

    mem_image_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] mem     [MAX_WORDS];
    logic [DATA_W-1:0] exp_mem [MAX_WORDS];
    logic [DATA_W-1:0] flip;
    logic [ADDR_W-1:0] wr_log  [$];
    int checks   = 0;
    int failures = 0;
    int we_cnt, done_cnt;

    // Distributed memory model: synchronous write, asynchronous read.
    assign bus.mem_dpo = mem[bus.mem_dpra] ^ flip;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_a] <= bus.mem_d;
            we_cnt++;
            wr_log.push_back(bus.mem_a);
        end
        if (bus.done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < int'(MAX_WORDS); i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    task automatic feed_byte(input logic [7:0] b, input int gap_pct, input string tag);
        int g = 0;
        while ($urandom_range(0, 99) < gap_pct) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({tag, ".accept"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input int unsigned count);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = (ADDR_W + 1)'(count);
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic run_load(input logic [ADDR_W-1:0] base, input int unsigned count,
                            input logic [DATA_W-1:0] words [$], input int gap_pct,
                            input bit exp_err, input string tag);
        int unsigned eff;
        logic [DATA_W-1:0] exp_sum = '0;
        logic [ADDR_W-1:0] exp_addr [$];
        int g = 0;
        int bad = 0;
        eff = (count > MAX_WORDS) ? MAX_WORDS : count;
        for (int i = 0; i < int'(eff); i++) begin
            exp_addr.push_back(ADDR_W'((int'(base) + i) % int'(MAX_WORDS)));
            exp_mem[exp_addr[i]] = words[i];
            exp_sum += words[i];
        end
        we_cnt = 0;
        done_cnt = 0;
        wr_log.delete();
        pulse_start(base, count);
        check({tag, ".busy_after_start"}, 64'(bus.busy), 64'd1);
        check({tag, ".err_cleared"}, 64'(bus.verify_err), 64'd0);
        check({tag, ".sum_cleared"}, 64'(bus.checksum), 64'd0);
        for (int i = 0; i < int'(eff); i++)
            for (int b = 0; b < int'(BYTES_PER_WORD); b++)
                feed_byte(words[i][DATA_W-1-8*b -: 8], gap_pct, tag);
        while (!bus.done && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check({tag, ".done"}, 64'(bus.done), 64'd1);
        if (eff == 0) check({tag, ".empty_latency"}, 64'(g), 64'd1);
        check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, ".checksum"}, 64'(bus.checksum), 64'(exp_sum));
        check({tag, ".verify_err"}, 64'(bus.verify_err), 64'(exp_err));
        @(negedge clk);
        check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, ".checksum_hold"}, 64'(bus.checksum), 64'(exp_sum));
        check({tag, ".done_count"}, 64'(done_cnt), 64'd1);
        check({tag, ".we_count"}, 64'(we_cnt), 64'(eff));
        check({tag, ".mem_image"}, 64'(mem_diff()), 64'd0);
        if (wr_log.size() != exp_addr.size()) bad++;
        else foreach (exp_addr[i]) if (wr_log[i] !== exp_addr[i]) bad++;
        check({tag, ".wr_addrs"}, 64'(bad), 64'd0);
    endtask

    function automatic void rand_words(input int n, output logic [DATA_W-1:0] q [$]);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back($urandom());
    endfunction

    initial begin
        logic [DATA_W-1:0] w [$];
        rst = 1'b1;
        flip = '0;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        bus.in_byte = '0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < int'(MAX_WORDS); i++) begin
            mem[i] = $urandom();
            exp_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.in_ready", 64'(bus.in_ready), 64'd0);
        check("reset.mem_we", 64'(bus.mem_we), 64'd0);
        check("reset.outs", 64'({bus.mem_a, bus.mem_d, bus.mem_dpra, bus.verify_err}), 64'd0);
        check("reset.checksum", 64'(bus.checksum), 64'd0);
        rst = 1'b0;

        // Known vector, MSB-first packing.
        w = '{32'h3C013DCC, 32'h3421CCCD};
        run_load(8'h10, 2, w, 0, 1'b0, "vec");
        check("vec.word0", 64'(mem[8'h10]), 64'h3C013DCC);
        check("vec.word1", 64'(mem[8'h11]), 64'h3421CCCD);

        // Address wrap at the top of memory.
        rand_words(4, w);
        run_load(8'hFE, 4, w, 0, 1'b0, "wrap");

        run_load(8'h55, 0, w, 0, 1'b0, "empty");

        // Same image with and without input gaps.
        rand_words(16, w);
        run_load(8'h40, 16, w, 0, 1'b0, "nogap");
        run_load(8'h40, 16, w, 50, 1'b0, "gap");

        // Corrupted read-back data must raise the flag; the next start clears it.
        flip = 32'h0000_0100;
        rand_words(3, w);
        run_load(8'h20, 3, w, 0, 1'b1, "corrupt");
        flip = '0;
        rand_words(1, w);
        run_load(8'h30, 1, w, 10, 1'b0, "after_err");

        // Oversized request clamps to a full pass over memory.
        rand_words(256, w);
        run_load(8'h33, 300, w, 0, 1'b0, "clamp");

        // Reset in the middle of word 2; a start pulse while busy must be ignored.
        rand_words(4, w);
        pulse_start(8'h80, 4);
        for (int b = 0; b < int'(BYTES_PER_WORD); b++)
            feed_byte(w[0][DATA_W-1-8*b -: 8], 0, "mid");
        check("mid.write_we", 64'(bus.mem_we), 64'd1);
        check("mid.write_not_ready", 64'(bus.in_ready), 64'd0);
        check("mid.write_addr", 64'(bus.mem_a), 64'h80);
        check("mid.write_data", 64'(bus.mem_d), 64'(w[0]));
        pulse_start(8'h00, 1);
        for (int b = 0; b < int'(BYTES_PER_WORD); b++)
            feed_byte(w[1][DATA_W-1-8*b -: 8], 0, "mid");
        feed_byte(w[2][DATA_W-1 -: 8], 0, "mid");
        feed_byte(w[2][DATA_W-9 -: 8], 0, "mid");
        exp_mem[8'h80] = w[0];
        exp_mem[8'h81] = w[1];
        rst = 1'b1;
        #1;
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.in_ready", 64'(bus.in_ready), 64'd0);
        check("rst.mem_we", 64'(bus.mem_we), 64'd0);
        check("rst.outs", 64'({bus.mem_a, bus.mem_d, bus.mem_dpra, bus.done, bus.verify_err}),
              64'd0);
        check("rst.checksum", 64'(bus.checksum), 64'd0);
        @(negedge clk);
        check("rst.mem_image", 64'(mem_diff()), 64'd0);
        rst = 1'b0;
        rand_words(5, w);
        run_load(8'h80, 5, w, 25, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
